// File: rtl/yuv_pkg.sv
// Shared constants, UYVY byte-lane layout and packer state type for the YUV422 output stage.
package yuv_pkg;

  localparam int PIX_W   = 8;
  localparam int PIXEL_W = 3 * PIX_W;
  localparam int PAIR_W  = 32;
  localparam int WORD_W  = 64;

  // Byte lanes of a UYVY pair word
  localparam int U_LSB  = 0;
  localparam int Y0_LSB = 8;
  localparam int V_LSB  = 16;
  localparam int Y1_LSB = 24;

  // Component offsets within one {Y, U, V} pixel
  localparam int PIX_V_LSB = 0;
  localparam int PIX_U_LSB = 8;
  localparam int PIX_Y_LSB = 16;

  typedef enum logic {
    PK_EMPTY,
    PK_HALF
  } pk_state_t;

endpackage

// File: rtl/yuv_pair_formatter.sv
// Stage 1: turns two YUV444 pixels into one registered UYVY pair word.
// Chroma is the rounded pair average when YUV422_CHROMA_AVG_EN is defined, else taken from pixel 0.
module yuv_pair_formatter #(
  parameter int PIX_W = 8
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                frame_valid,
  input  logic                line_valid,
  input  logic                pixel_valid,
  input  logic [6*PIX_W-1:0]  pixel_data,
  output logic                s1_valid,
  output logic                s1_lv,
  output logic                s1_fv,
  output logic [4*PIX_W-1:0]  s1_pair
);
  import yuv_pkg::*;

  logic [PIX_W-1:0]   y0, y1, u0, u1, v0, v1;
  logic [PIX_W-1:0]   u_sel, v_sel;
  logic [4*PIX_W-1:0] pair_c;
  logic               accept;

  assign y0 = pixel_data[PIX_Y_LSB +: PIX_W];
  assign u0 = pixel_data[PIX_U_LSB +: PIX_W];
  assign v0 = pixel_data[PIX_V_LSB +: PIX_W];
  assign y1 = pixel_data[PIXEL_W + PIX_Y_LSB +: PIX_W];
  assign u1 = pixel_data[PIXEL_W + PIX_U_LSB +: PIX_W];
  assign v1 = pixel_data[PIXEL_W + PIX_V_LSB +: PIX_W];

`ifdef YUV422_CHROMA_AVG_EN
  // One extra bit keeps the rounded sum exact, so the average never saturates
  logic [PIX_W:0] u_sum, v_sum;
  assign u_sum = {1'b0, u0} + {1'b0, u1} + (PIX_W+1)'(1);
  assign v_sum = {1'b0, v0} + {1'b0, v1} + (PIX_W+1)'(1);
  assign u_sel = u_sum[PIX_W:1];
  assign v_sel = v_sum[PIX_W:1];
`else
  logic unused_chroma;
  assign unused_chroma = ^{u1, v1};
  assign u_sel = u0;
  assign v_sel = v0;
`endif

  always_comb begin
    pair_c                   = '0;
    pair_c[U_LSB  +: PIX_W]  = u_sel;
    pair_c[Y0_LSB +: PIX_W]  = y0;
    pair_c[V_LSB  +: PIX_W]  = v_sel;
    pair_c[Y1_LSB +: PIX_W]  = y1;
  end

  assign accept = pixel_valid & line_valid;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_valid <= 1'b0;
      s1_lv    <= 1'b0;
      s1_fv    <= 1'b0;
      s1_pair  <= '0;
    end else begin
      s1_valid <= accept;
      s1_lv    <= line_valid;
      s1_fv    <= frame_valid;
      if (accept) begin
        s1_pair <= pair_c;
      end
    end
  end

endmodule

// File: rtl/yuv422_packer.sv
// YUV444 pixel pairs -> 64-bit UYVY words (two pairs per word), frame/line valids delayed 3 cycles.
// Build option YUV422_CHROMA_AVG_EN selects rounded chroma averaging in the pair formatter.
module yuv422_packer #(
  parameter int PIX_W = 8
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                frame_valid_i,
  input  logic                line_valid_i,
  input  logic                pixel_valid_i,
  input  logic [6*PIX_W-1:0]  pixel_data_i,
  output logic                frame_valid_o,
  output logic                line_valid_o,
  output logic                yuv_valid_o,
  output logic [8*PIX_W-1:0]  yuv_data_o,
  output logic                protocol_err_o
);
  import yuv_pkg::*;

  logic                s1_valid, s1_lv, s1_fv;
  logic [4*PIX_W-1:0]  s1_pair;
  logic                lv_d2, fv_d2;
  logic                fv_rise, lv_fall;

  pk_state_t           state, state_nxt;
  logic [4*PIX_W-1:0]  hold, hold_nxt;
  logic                out_vld_nxt;
  logic [8*PIX_W-1:0]  out_dat_nxt;

  yuv_pair_formatter #(.PIX_W(PIX_W)) u_fmt (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .frame_valid (frame_valid_i),
    .line_valid  (line_valid_i),
    .pixel_valid (pixel_valid_i),
    .pixel_data  (pixel_data_i),
    .s1_valid    (s1_valid),
    .s1_lv       (s1_lv),
    .s1_fv       (s1_fv),
    .s1_pair     (s1_pair)
  );

  // lv_d2/fv_d2 double as the previous-cycle values of the stage-1 envelopes
  assign fv_rise = s1_fv & ~fv_d2;
  assign lv_fall = ~s1_lv & lv_d2;

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold;
    out_vld_nxt = 1'b0;
    out_dat_nxt = yuv_data_o;
    if (fv_rise) begin
      // New frame: a stale half word is dropped; a pair arriving now starts the frame
      state_nxt = PK_EMPTY;
      hold_nxt  = '0;
      if (s1_valid) begin
        hold_nxt  = s1_pair;
        state_nxt = PK_HALF;
      end
    end else begin
      case (state)
        PK_EMPTY: begin
          if (s1_valid) begin
            hold_nxt  = s1_pair;
            state_nxt = PK_HALF;
          end
        end
        PK_HALF: begin
          if (s1_valid) begin
            out_vld_nxt = 1'b1;
            out_dat_nxt = {s1_pair, hold};
            state_nxt   = PK_EMPTY;
          end else if (lv_fall) begin
            out_vld_nxt = 1'b1;
            out_dat_nxt = {{(4*PIX_W){1'b0}}, hold};
            state_nxt   = PK_EMPTY;
          end
        end
        default: state_nxt = PK_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= PK_EMPTY;
      hold           <= '0;
      yuv_valid_o    <= 1'b0;
      yuv_data_o     <= '0;
      lv_d2          <= 1'b0;
      fv_d2          <= 1'b0;
      line_valid_o   <= 1'b0;
      frame_valid_o  <= 1'b0;
      protocol_err_o <= 1'b0;
    end else begin
      state          <= state_nxt;
      hold           <= hold_nxt;
      yuv_valid_o    <= out_vld_nxt;
      yuv_data_o     <= out_dat_nxt;
      lv_d2          <= s1_lv;
      fv_d2          <= s1_fv;
      line_valid_o   <= lv_d2;
      frame_valid_o  <= fv_d2;
      protocol_err_o <= protocol_err_o | (pixel_valid_i & ~line_valid_i);
    end
  end

endmodule

// File: tb/tb_yuv422_packer.sv
// Randomized and directed bench for yuv422_packer against a pair-queue reference model.
`timescale 1ns/1ps
module tb_yuv422_packer;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        frame_valid_i, line_valid_i, pixel_valid_i;
  logic [47:0] pixel_data_i;
  logic        frame_valid_o, line_valid_o, yuv_valid_o, protocol_err_o;
  logic [63:0] yuv_data_o;

  yuv422_packer #(.PIX_W(8)) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .frame_valid_i  (frame_valid_i),
    .line_valid_i   (line_valid_i),
    .pixel_valid_i  (pixel_valid_i),
    .pixel_data_i   (pixel_data_i),
    .frame_valid_o  (frame_valid_o),
    .line_valid_o   (line_valid_o),
    .yuv_valid_o    (yuv_valid_o),
    .yuv_data_o     (yuv_data_o),
    .protocol_err_o (protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] word;
    int          at;
  } exp_t;

  exp_t        exp_q[$];
  logic        pend_v  = 1'b0;
  logic [31:0] pend    = '0;
  logic        prev_lv = 1'b0;
  logic        prev_fv = 1'b0;
  logic        err_exp = 1'b0;
  logic        err_seen = 1'b0;
  logic [2:0]  fvh = '0, lvh = '0;
  logic [63:0] last_word = '0;
  int          words_seen = 0;

  localparam logic [47:0] UNI_PAIR = 48'h4dff55_4dff55;
  localparam logic [47:0] CHR_PAIR = 48'h221321_111020;
`ifdef YUV422_CHROMA_AVG_EN
  localparam logic [31:0] CHR_WORD = 32'h22211112;
`else
  localparam logic [31:0] CHR_WORD = 32'h22201110;
`endif

  function automatic logic [31:0] uyvy(input logic [47:0] d);
    logic [7:0] u, v;
`ifdef YUV422_CHROMA_AVG_EN
    int su, sv;
    su = int'(d[15:8]) + int'(d[39:32]) + 1;
    sv = int'(d[7:0])  + int'(d[31:24]) + 1;
    u  = 8'(su / 2);
    v  = 8'(sv / 2);
`else
    u = d[15:8];
    v = d[7:0];
`endif
    return {d[47:40], v, d[23:16], u};
  endfunction

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (!reset_n_i) begin
      fvh      <= '0;
      lvh      <= '0;
      err_seen <= 1'b0;
    end else begin
      fvh      <= {fvh[1:0], frame_valid_i};
      lvh      <= {lvh[1:0], line_valid_i};
      err_seen <= err_exp;
    end
  end

  always @(negedge clk_i) begin
    if (reset_n_i) begin
      total++;
      if (frame_valid_o !== fvh[2]) begin
        bad++; $display("FAIL fv_delay cyc=%0d got=%b want=%b", cyc, frame_valid_o, fvh[2]);
      end
      total++;
      if (line_valid_o !== lvh[2]) begin
        bad++; $display("FAIL lv_delay cyc=%0d got=%b want=%b", cyc, line_valid_o, lvh[2]);
      end
      total++;
      if (protocol_err_o !== err_seen) begin
        bad++; $display("FAIL protocol_err cyc=%0d got=%b want=%b", cyc, protocol_err_o, err_seen);
      end
      if (yuv_valid_o === 1'b1) begin
        words_seen++;
        total++;
        if (line_valid_o !== 1'b1) begin
          bad++; $display("FAIL word_in_line cyc=%0d line_valid_o=%b want=1", cyc, line_valid_o);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL unexpected_word cyc=%0d got=%h want=none", cyc, yuv_data_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (yuv_data_o !== e.word) begin
            bad++; $display("FAIL word_data cyc=%0d got=%h want=%h", cyc, yuv_data_o, e.word);
          end
          total++;
          if (cyc != e.at) begin
            bad++; $display("FAIL word_time got_cyc=%0d want_cyc=%0d", cyc, e.at);
          end
        end
        last_word = yuv_data_o;
      end else begin
        total++;
        if (yuv_data_o !== last_word) begin
          bad++; $display("FAIL data_hold cyc=%0d got=%h want=%h", cyc, yuv_data_o, last_word);
        end
      end
    end
  end

  // One input cycle: update the model with the spec's rules, then advance to edge+1
  task automatic drive(input logic fv, input logic lv, input logic pv, input logic [47:0] d);
    exp_t        e;
    logic [31:0] p;
    frame_valid_i = fv;
    line_valid_i  = lv;
    pixel_valid_i = pv;
    pixel_data_i  = d;
    if (fv && !prev_fv) pend_v = 1'b0;
    if (!lv && prev_lv && pend_v) begin
      e.word = {32'h0, pend};
      e.at   = cyc + 2;
      exp_q.push_back(e);
      pend_v = 1'b0;
    end
    if (pv && lv) begin
      p = uyvy(d);
      if (pend_v) begin
        e.word = {p, pend};
        e.at   = cyc + 2;
        exp_q.push_back(e);
        pend_v = 1'b0;
      end else begin
        pend   = p;
        pend_v = 1'b1;
      end
    end
    if (pv && !lv) err_exp = 1'b1;
    prev_lv = lv;
    prev_fv = fv;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input logic fv, input int n);
    for (int i = 0; i < n; i++) drive(fv, 1'b0, 1'b0, 48'h0);
  endtask

  task automatic apply_reset();
    #2 reset_n_i = 1'b0;
    #1;
    total++;
    if ({frame_valid_o, line_valid_o, yuv_valid_o, protocol_err_o} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000", {frame_valid_o, line_valid_o, yuv_valid_o, protocol_err_o});
    end
    total++;
    if (yuv_data_o !== 64'h0) begin
      bad++; $display("FAIL reset_data got=%h want=0", yuv_data_o);
    end
    frame_valid_i = 1'b0; line_valid_i = 1'b0; pixel_valid_i = 1'b0; pixel_data_i = '0;
    exp_q.delete();
    pend_v = 1'b0; prev_lv = 1'b0; prev_fv = 1'b0; err_exp = 1'b0;
    last_word = '0;
    repeat (2) @(posedge clk_i);
    #3 reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_words(input string name, input int want_n, input logic [63:0] want_w);
    total++;
    if (words_seen != want_n) begin
      bad++; $display("FAIL %s_count got=%0d want=%0d", name, words_seen, want_n);
    end
    total++;
    if (last_word !== want_w) begin
      bad++; $display("FAIL %s_word got=%h want=%h", name, last_word, want_w);
    end
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_uniform_line();
    words_seen = 0;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b1, UNI_PAIR);
    idle(1'b1, 5);
    check_words("uniform", 2, 64'h4d554dff4d554dff);
  endtask

  task automatic test_odd_line();
    words_seen = 0;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, UNI_PAIR);
    idle(1'b1, 5);
    check_words("odd", 2, 64'h000000004d554dff);
  endtask

  task automatic test_chroma();
    words_seen = 0;
    drive(1'b1, 1'b1, 1'b1, CHR_PAIR);
    drive(1'b1, 1'b1, 1'b1, CHR_PAIR);
    idle(1'b1, 5);
    check_words("chroma", 1, {CHR_WORD, CHR_WORD});
  endtask

  task automatic test_random();
    for (int l = 0; l < 8; l++) begin
      int n;
      n = $urandom_range(1, 7);
      for (int p = 0; p < n; p++) begin
        int gaps;
        gaps = $urandom_range(0, 2);
        for (int g = 0; g < gaps; g++) drive(1'b1, 1'b1, 1'b0, {16'($urandom), $urandom});
        drive(1'b1, 1'b1, 1'b1, {16'($urandom), $urandom});
      end
      idle(1'b1, $urandom_range(1, 3));
      if ($urandom_range(0, 2) == 0) idle(1'b0, 1);
    end
    idle(1'b1, 5);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL random_drain left=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_frame_restart();
    logic [47:0] a, b, c;
    a = 48'h0a0b0c_010203;
    b = 48'h6a7b8c_615263;
    c = 48'h9a8b7c_918273;
    idle(1'b0, 2);
    words_seen = 0;
    drive(1'b1, 1'b1, 1'b1, a);
    drive(1'b0, 1'b1, 1'b0, 48'h0);
    drive(1'b1, 1'b1, 1'b1, b);
    drive(1'b1, 1'b1, 1'b1, c);
    idle(1'b1, 5);
    check_words("frame_restart", 1, {uyvy(c), uyvy(b)});
  endtask

  task automatic test_protocol();
    words_seen = 0;
    drive(1'b1, 1'b0, 1'b1, UNI_PAIR);
    total++;
    if (protocol_err_o !== 1'b1) begin
      bad++; $display("FAIL protocol_set got=%b want=1", protocol_err_o);
    end
    idle(1'b1, 4);
    total++;
    if (words_seen != 0) begin
      bad++; $display("FAIL protocol_drop got=%0d want=0", words_seen);
    end
    drive(1'b1, 1'b1, 1'b1, CHR_PAIR);
    drive(1'b1, 1'b1, 1'b1, UNI_PAIR);
    idle(1'b1, 5);
    total++;
    if (protocol_err_o !== 1'b1) begin
      bad++; $display("FAIL protocol_sticky got=%b want=1", protocol_err_o);
    end
  endtask

  task automatic test_reset_midline();
    logic [47:0] a, b;
    a = 48'h335577_224466;
    b = 48'h99aabb_ccddee;
    drive(1'b1, 1'b1, 1'b1, UNI_PAIR);
    drive(1'b1, 1'b1, 1'b0, 48'h0);
    apply_reset();
    words_seen = 0;
    drive(1'b1, 1'b1, 1'b1, a);
    drive(1'b1, 1'b1, 1'b1, b);
    idle(1'b1, 5);
    check_words("reset_midline", 1, {uyvy(b), uyvy(a)});
  endtask

  initial begin
    reset_n_i     = 1'b1;
    frame_valid_i = 1'b0;
    line_valid_i  = 1'b0;
    pixel_valid_i = 1'b0;
    pixel_data_i  = '0;
    #1;
    test_reset();
    test_uniform_line();
    test_odd_line();
    test_chroma();
    test_random();
    test_frame_restart();
    test_protocol();
    test_reset_midline();
    idle(1'b0, 4);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL final_drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
